// File: rtl/seg_display_module_if.sv
// seg_display_module_if
//   CPU write port of the seven-segment display driver.
//   we    : one-cycle write strobe (CPU -> display)
//   wdata : 32-bit write data, sampled when we=1 (CPU -> display)
//   wack  : one-cycle write acknowledge (display -> CPU)
//   Modports: master (CPU side), slave (display side).
interface seg_display_module_if;
    logic        we;
    logic [31:0] wdata;
    logic        wack;

    modport master (output we, output wdata, input wack);
    modport slave  (input we, input wdata, output wack);
endinterface

// File: rtl/seg_display_module.sv
// seg_display_module
//   Write-only seven-segment display driver. The CPU writes a 32-bit word;
//   the low 4*NDIG bits are shown as hex digits, time-multiplexed onto a
//   common-anode display. New values are committed only at frame end so a
//   frame never mixes old and new digits.
//
//   Parameters: NDIG (1..8) digits, SCAN_DIV (>=2) cycles per digit.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     cpu   : seg_display_module_if.slave (we, wdata, wack)
//     an    : digit anodes, active-low, one-hot-low, an[0] = rightmost
//     seg   : segments {g,f,e,d,c,b,a}, active-low
//     dp    : decimal point, active-low, constantly off
//   Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking.
module seg_display_module #(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg_display_module_if.slave    cpu,
    output logic [NDIG-1:0]        an,
    output logic [6:0]             seg,
    output logic                   dp
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DIG_LAST = DW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_RST   = ~NDIG'(1);
    localparam logic [6:0]      SEG_ZERO = 7'b1000000;
    localparam logic [6:0]      SEG_OFF  = 7'b1111111;

    logic [31:0]   pend;
    logic          pend_v;
    logic [31:0]   disp;
    logic [CW-1:0] div_cnt;
    logic [DW-1:0] dig;

    logic          div_last;
    logic          frame_end;
    logic [DW-1:0] dig_nxt;
    logic [31:0]   disp_nxt;
    logic [3:0]    nib_nxt;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        div_last  = (div_cnt == DIV_LAST);
        frame_end = div_last && (dig == DIG_LAST);
        dig_nxt   = (dig == DIG_LAST) ? '0 : dig + 1'b1;

        // A write landing exactly on the frame-end cycle bypasses pend.
        disp_nxt = disp;
        if (frame_end) begin
            if (cpu.we)
                disp_nxt = cpu.wdata;
            else if (pend_v)
                disp_nxt = pend;
        end

        nib_nxt = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (dig_nxt == DW'(k))
                nib_nxt = disp_nxt[4*k +: 4];
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic [NDIG-1:0] blank;
    logic [NDIG-1:0] blank_nxt;
    logic            blank_sel;

    // Digit k is blank when it and every digit above it are zero; digit 0
    // is never blank. Recomputed from the committed value only.
    always_comb begin
        logic upper_zero;
        blank_nxt  = blank;
        upper_zero = 1'b1;
        if (frame_end) begin
            blank_nxt = '0;
            for (int unsigned k = NDIG - 1; k >= 1; k--) begin
                upper_zero   = upper_zero && (disp_nxt[4*k +: 4] == 4'h0);
                blank_nxt[k] = upper_zero;
            end
        end

        blank_sel = 1'b0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (dig_nxt == DW'(k))
                blank_sel = blank_nxt[k];
        end
        seg_nxt = blank_sel ? SEG_OFF : hex7(nib_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blank <= AN_RST;
        else
            blank <= blank_nxt;
    end
`else
    always_comb begin
        seg_nxt = hex7(nib_nxt);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            pend_v  <= 1'b0;
            disp    <= '0;
            div_cnt <= '0;
            dig     <= '0;
            cpu.wack <= 1'b0;
            an      <= AN_RST;
            seg     <= SEG_ZERO;
        end else begin
            cpu.wack <= cpu.we;
            if (cpu.we)
                pend <= cpu.wdata;
            pend_v <= frame_end ? 1'b0 : (pend_v | cpu.we);
            disp   <= disp_nxt;
            if (div_last) begin
                div_cnt <= '0;
                dig     <= dig_nxt;
                an      <= ~(NDIG'(1) << dig_nxt);
                seg     <= seg_nxt;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_module.sv
// tb_seg_display_module
//   Self-checking bench for seg_display_module (NDIG=4, SCAN_DIV=4).
//   The reference model tracks time as an edge count since reset: the
//   visible digit is (m/4)%4, frames end every 16 edges, and the displayed
//   value follows the last-write-wins / frame-end commit rules.
module tb_seg_display_module;

    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = NDIG * SCAN_DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg_display_module_if bus ();

    seg_display_module #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (bus.slave),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n_checks;
    int          n_fail;
    int          m;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    bit          m_pend_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d);
        logic [31:0] shown;
        shown = v & 32'h0000_FFFF;
`ifdef SEG_LZ_BLANK_EN
        if (d > 0 && (shown >> (4 * d)) == 0)
            return 7'b1111111;
`endif
        return hex_tab[(shown >> (4 * d)) & 32'hF];
    endfunction

    task automatic check_outputs(input string tag, input logic exp_wack);
        int d;
        logic [3:0] exp_an;
        d = (m / SCAN_DIV) % NDIG;
        exp_an = ~(4'b0001 << d);
        check({tag, ".an"},   {28'b0, an},       {28'b0, exp_an});
        check({tag, ".seg"},  {25'b0, seg},      {25'b0, exp_seg(m_disp, d)});
        check({tag, ".dp"},   {31'b0, dp},       32'd1);
        check({tag, ".wack"}, {31'b0, bus.wack}, {31'b0, exp_wack});
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, check.
    task automatic cycle(input string tag, input logic w, input logic [31:0] d);
        bus.we    = w;
        bus.wdata = d;
        @(posedge clk);
        if (w) begin
            m_pend   = d;
            m_pend_v = 1'b1;
        end
        if (m % FRAME == FRAME - 1) begin
            if (w)
                m_disp = d;
            else if (m_pend_v)
                m_disp = m_pend;
            m_pend_v = 1'b0;
        end
        m++;
        #1;
        check_outputs(tag, w);
        bus.we = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cycle(tag, 1'b0, 32'h0);
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < FRAME && (m % FRAME) != phase; i++)
            cycle("align", 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        m_disp   = '0;
        m_pend   = '0;
        m_pend_v = 1'b0;
        m        = 0;
        check_outputs("rst_async", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst_hold", 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m         = 0;
        m_disp    = '0;
        m_pend    = '0;
        m_pend_v  = 1'b0;
        rst_n     = 1'b1;
        bus.we    = 1'b0;
        bus.wdata = '0;
        #1;

        // Reset and free-running scan.
        do_reset();
        idle("scan", 2 * FRAME);

        // Write mid-frame, visible only from the next frame.
        align(2);
        cycle("w1234", 1'b1, 32'h0000_1234);
        idle("f1234", 2 * FRAME);

        // Last write wins.
        align(5);
        cycle("wAAAA", 1'b1, 32'h0000_AAAA);
        cycle("w0F0F", 1'b1, 32'h0000_0F0F);
        idle("f0F0F", 2 * FRAME);

        // Bypass on the frame-end cycle.
        align(FRAME - 1);
        cycle("wBEEF", 1'b1, 32'h0000_BEEF);
        idle("fBEEF", FRAME);

        // Reset with a write still pending.
        align(3);
        cycle("w9999", 1'b1, 32'h9999_9999);
        do_reset();
        idle("post_rst", 2 * FRAME);

        // Small value (leading zeros).
        align(1);
        cycle("w0005", 1'b1, 32'h0000_0005);
        idle("f0005", 2 * FRAME);

        // Value with upper (undisplayed) bits set.
        align(7);
        cycle("whigh", 1'b1, 32'hFFFF_0000);
        idle("fhigh", 2 * FRAME);

        // Randomized traffic, values often narrowed to exercise leading zeros.
        for (int i = 0; i < 600; i++) begin
            logic        w;
            logic [31:0] d;
            w = ($urandom_range(0, 5) == 0);
            d = $urandom() >> $urandom_range(0, 31);
            cycle("rand", w, d);
        end
        idle("drain", 2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_module.md
# seg_display_module

CPU-facing write-only seven-segment display driver: the output-side counterpart to the button read port. Accepts a 32-bit word written by the CPU with a one-cycle write strobe. Holds the word and time-multiplexes its low 4·NDIG bits as hexadecimal digits onto a common-anode display. New values are committed only at scan-frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NDIG, 4: number of display digits (1..8).
- SCAN_DIV, 50000: clock cycles each digit stays lit (≥2).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- we  in  1  write strobe; one cycle per write.
- wdata  in  32  CPU write data, sampled when we=1.
- wack  out  1  one-cycle write acknowledge.
- an  out  NDIG  digit anodes, active-low, one-hot-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; constant 1 (off).

## Operation
- Registers:
  - pend: 32-bit pending value, with pend_v valid flag.
  - disp: 32-bit committed display value.
  - div_cnt: divider, counts 0..SCAN_DIV-1.
  - dig: digit index, counts 0..NDIG-1.
- Write:
  - we=1 loads pend<=wdata and sets pend_v.
  - Back-to-back or repeated writes before a commit: last write wins, and every write is acked.
- Scan:
  - div_cnt increments every cycle. At SCAN_DIV-1 it wraps to 0 and dig advances.
  - dig wraps from NDIG-1 to 0.
- Frame end: the cycle with div_cnt==SCAN_DIV-1 and dig==NDIG-1.
- Commit, at frame end:
  - If we=1 in that cycle, wdata is committed directly to disp (bypass) and pend_v clears.
  - Else if pend_v, disp<=pend and pend_v clears.
  - Else disp is unchanged.
- Digit k shows disp[4k+3:4k]. Digit 0 is the rightmost digit and drives an[0].
- Hex decode (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Bits of disp above 4·NDIG are stored but never displayed.

## Timing
- Reset values (async on rst_n=0):
  - pend=0, pend_v=0, disp=0, div_cnt=0, dig=0, wack=0.
  - an = all ones except an[0]=0.
  - seg=1000000; dp=1.
- wack rises the cycle after we is sampled and lasts exactly one cycle.
- an and seg are registered and change on the same edge: the edge after div_cnt==SCAN_DIV-1.
  - The new value reflects the new dig and the post-commit disp.
- Write-to-visible latency:
  - Minimum 1 cycle (write in the frame-end cycle).
  - Maximum NDIG·SCAN_DIV cycles.
- Reset mid-frame discards pend and disp. Scanning restarts at digit 0.
- Full frame period: exactly NDIG·SCAN_DIV cycles. No blanking gap between digits.

## Configuration
- SEG_LZ_BLANK_EN:
  - Defined: leading-zero blanking.
    - At commit, digits above the most significant non-zero digit are flagged blank.
    - Blank digits drive seg=1111111 while their anode is still scanned.
    - Digit 0 is never blanked, so value 0 shows a single "0".
    - Reset state has digits 1..NDIG-1 blanked.
  - Undefined: all NDIG digits are always decoded, including leading zeros.

## Test plan
Bench uses NDIG=4, SCAN_DIV=4.

1. Reset behaviour:
   - Stimulus: assert rst_n=0, then release; run 16 cycles.
   - Response: an steps 1110→1101→1011→0111 every 4 cycles. seg=1000000 on digit 0, dp=1, wack=0.
2. Frame-boundary commit:
   - Stimulus: write 0x00001234 at cycle 2 of a frame.
   - Response: wack pulses 1 cycle later. disp is unchanged until the frame end. The next frame shows digit0=4 (0011001), digit1=3, digit2=2, digit3=1.
3. Last write wins:
   - Stimulus: write 0xAAAA then 0x0F0F in consecutive cycles within one frame.
   - Response: two wack pulses. The next frame shows F,0,F,0 on digits 0..3.
4. Bypass write:
   - Stimulus: write 0xBEEF exactly in the frame-end cycle.
   - Response: the following digit-0 period already shows F (0001110).
5. Reset mid-operation:
   - Stimulus: a pending write is outstanding and rst_n drops.
   - Response: outputs immediately return to reset values; the pending value is never displayed.
6. SEG_LZ_BLANK_EN:
   - Stimulus: write 0x0000005.
   - Response: with the macro, digits 1..3 show seg=1111111 and digit 0 shows 0010010. Without it, digits 1..3 show 1000000.
